instr_fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core, directly upstream of the control unit. Holds the program counter, requests instructions from the instruction cache over a request/ready handshake, and presents one instruction (and its PC) to the decode/control path. The next PC is then chosen from the control unit's `PCSrc` decision and the branch/jump target. Miss latency is tolerated by waiting on the cache. Downstream back-pressure is tolerated by holding the presented instruction.

---
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RISC-V instruction fetch stage.
// Holds the PC, issues word reads to the instruction cache over a req/ready
// handshake, presents one instruction at a time to decode and retires it
// when downstream is not stalled. The next PC is either sequential or the
// control unit's branch/jump target.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        stall,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ready,
    input  logic [31:0] ic_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    // Word-aligned reset address; low bits are forced to zero.
    localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> FETCH -> ISSUE -> FETCH ...
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (ic_ready) state_d = S_ISSUE;
            S_ISSUE: if (!stall)   state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        ic_req      = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_FETCH: ic_req      = 1'b1;
            S_ISSUE: instr_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: capture on cache return, advance PC on retire.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        instret_d  = instret_q;
        if (state_q == S_FETCH && ic_ready) begin
            instr_d = ic_rdata;
            pc_d    = fetch_pc_q;
        end
        if (state_q == S_ISSUE && !stall) begin
            fetch_pc_d = PCSrc ? {PCTarget[31:2], 2'b00} : (pc_q + 32'd4);
            instret_d  = instret_q + 32'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_ADDR;
            instr_q    <= '0;
            pc_q       <= '0;
            instret_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            instret_q  <= instret_d;
        end
    end

    assign ic_addr  = fetch_pc_q;
    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign instret  = instret_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with RESET_PC = 0x100.
// Cache model: on a hit, returns ic_addr + 0x1300_0000 as the instruction.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        stall;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic [31:0] ic_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;

    logic        garbage;
    logic [31:0] garbage_val;

    int n_cmp;
    int n_err;

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .stall      (stall),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_ready   (ic_ready),
        .ic_rdata   (ic_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instret    (instret)
    );

    assign ic_rdata = garbage ? garbage_val : (ic_addr + 32'h1300_0000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        PCSrc       = 1'b0;
        PCTarget    = '0;
        stall       = 1'b0;
        ic_ready    = 1'b1;
        garbage     = 1'b0;
        garbage_val = '0;

        // Reset state
        @(negedge clk);
        step();
        check("rst_req",     {31'd0, ic_req},      32'd0);
        check("rst_valid",   {31'd0, instr_valid}, 32'd0);
        check("rst_addr",    ic_addr,              32'h0000_0100);
        check("rst_pc",      pc,                   32'h0);
        check("rst_pc4",     pc_plus4,             32'h4);
        check("rst_instr",   instr,                32'h0);
        check("rst_instret", instret,              32'h0);

        // IDLE cycle after release
        reset = 1'b0;
        #1;
        check("idle_req", {31'd0, ic_req}, 32'd0);
        step();
        check("f0_req",   {31'd0, ic_req},      32'd1);
        check("f0_addr",  ic_addr,              32'h0000_0100);
        check("f0_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("i0_valid", {31'd0, instr_valid}, 32'd1);
        check("i0_req",   {31'd0, ic_req},      32'd0);
        check("i0_pc",    pc,                   32'h0000_0100);
        check("i0_pc4",   pc_plus4,             32'h0000_0104);
        check("i0_instr", instr,                32'h1300_0100);

        // Branch to 0x2: low bits dropped, stream starts at 0
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_0002;
        step();
        PCSrc = 1'b0;
        check("br0_instret", instret, 32'd1);

        // Sequential stream 0x0/0x4/0x8; last retire branches to 0x20
        for (int i = 0; i < 3; i++) begin
            check("seq_f_valid", {31'd0, instr_valid}, 32'd0);
            check("seq_f_addr",  ic_addr,              32'(4 * i));
            step();
            check("seq_i_valid", {31'd0, instr_valid}, 32'd1);
            check("seq_i_pc",    pc,                   32'(4 * i));
            check("seq_i_instr", instr,                32'h1300_0000 + 32'(4 * i));
            if (i == 2) begin
                PCSrc    = 1'b1;
                PCTarget = 32'h0000_0020;
            end
            step();
        end
        check("seq_instret", instret, 32'd4);
        check("br20_addr",   ic_addr, 32'h0000_0020);

        // PCSrc asserted during FETCH is ignored
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_0080;
        step();
        check("br_i_pc", pc, 32'h0000_0020);
        PCTarget = 32'h0000_0043;
        step();
        PCSrc = 1'b0;
        check("br_addr",    ic_addr, 32'h0000_0040);
        check("br_instret", instret, 32'd5);
        step();
        check("br_pc", pc, 32'h0000_0040);

        // Miss: ic_ready low for 5 cycles with garbage on rdata
        ic_ready = 1'b0;
        garbage  = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            garbage_val = 32'hBAD0_0000 + 32'(k);
            check("miss_req",   {31'd0, ic_req},      32'd1);
            check("miss_addr",  ic_addr,              32'h0000_0044);
            check("miss_valid", {31'd0, instr_valid}, 32'd0);
            check("miss_instr", instr,                32'h1300_0040);
            step();
        end
        ic_ready = 1'b1;
        garbage  = 1'b0;
        check("miss6_req",  {31'd0, ic_req}, 32'd1);
        check("miss6_addr", ic_addr,         32'h0000_0044);
        step();
        check("miss_done_instr", instr, 32'h1300_0044);
        check("miss_done_pc",    pc,    32'h0000_0044);
        check("miss_instret",    instret, 32'd6);

        // Jump to 0xFFFF_FFFC, then stall 3 cycles
        PCSrc    = 1'b1;
        PCTarget = 32'hFFFF_FFFF;
        step();
        PCSrc = 1'b0;
        check("wrap_f_addr", ic_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc",  pc,       32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4, 32'h0);
        stall    = 1'b1;
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_0500;
        for (int s = 0; s < 3; s++) begin
            step();
            check("stall_valid",   {31'd0, instr_valid}, 32'd1);
            check("stall_pc",      pc,                   32'hFFFF_FFFC);
            check("stall_instr",   instr,                32'h12FF_FFFC);
            check("stall_instret", instret,              32'd7);
        end
        stall = 1'b0;
        PCSrc = 1'b0;
        step();
        check("wrap_addr",    ic_addr, 32'h0);
        check("wrap_instret", instret, 32'd8);

        // instret wrap from preloaded all-ones
        ic_ready = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("preload_instret", instret, 32'hFFFF_FFFF);
        ic_ready = 1'b1;
        step();
        check("pre_wrap_pc", pc, 32'h0);
        step();
        check("instret_wrap", instret, 32'h0);
        check("post_wrap_addr", ic_addr, 32'h4);

        // Asynchronous reset mid-miss
        ic_ready = 1'b0;
        step();
        check("mid_req", {31'd0, ic_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_req",     {31'd0, ic_req},      32'd0);
        check("areset_valid",   {31'd0, instr_valid}, 32'd0);
        check("areset_addr",    ic_addr,              32'h0000_0100);
        check("areset_instret", instret,              32'h0);
        @(negedge clk);
        reset    = 1'b0;
        ic_ready = 1'b1;
        #1;
        check("rel_idle_req", {31'd0, ic_req}, 32'd0);
        step();
        check("rel_req",     {31'd0, ic_req}, 32'd1);
        check("rel_addr",    ic_addr,         32'h0000_0100);
        check("rel_instret", instret,         32'h0);
        step();
        check("rel_pc",    pc,    32'h0000_0100);
        check("rel_instr", instr, 32'h1300_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
